// File: rtl/f_fetch_ctrl_if.sv
// Fetch-stage bundle: ID-stage redirect controls, hazard stall,
// instruction-memory handshake and F/D outputs.
interface f_fetch_ctrl_if;
    logic [1:0]  i_con_jump;
    logic        i_con_ifbranch;
    logic [31:0] i_addr_jump;
    logic [31:0] i_addr_jumpr;
    logic [31:0] i_addr_branch;
    logic        i_stall;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [31:0] o_addr_pc4;
    logic        o_flush;

    // Fetch controller side.
    modport master (
        input  i_con_jump, i_con_ifbranch, i_addr_jump, i_addr_jumpr,
               i_addr_branch, i_stall, i_imem_ack, i_imem_rdata,
        output o_imem_req, o_imem_addr, o_instr, o_instr_valid,
               o_addr_pc4, o_flush
    );

    // Environment side (ID stage, hazard unit, instruction memory).
    modport slave (
        output i_con_jump, i_con_ifbranch, i_addr_jump, i_addr_jumpr,
               i_addr_branch, i_stall, i_imem_ack, i_imem_rdata,
        input  o_imem_req, o_imem_addr, o_instr, o_instr_valid,
               o_addr_pc4, o_flush
    );
endinterface

// File: rtl/f_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory requests,
// applies branch/jr/j redirects, absorbs stalls with a one-entry skid.
module f_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    f_fetch_ctrl_if.master bus
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;
    logic [XLEN-1:0]   skid_q, skid_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic              req_q, req_d;

    logic              redirect_c;
    logic [XLEN-1:0]   target_raw_c;
    logic [XLEN-1:0]   target_c;
    logic [XLEN-1:0]   pc_inc_c;
    logic              flush_c;

    // Redirect decode and word-aligned target selection (branch > jr > j).
    always_comb begin
        redirect_c = !bus.i_stall && valid_q &&
                     (bus.i_con_ifbranch ||
                      bus.i_con_jump == 2'b01 ||
                      bus.i_con_jump == 2'b10);
        if (bus.i_con_ifbranch) begin
            target_raw_c = bus.i_addr_branch;
        end else if (bus.i_con_jump == 2'b10) begin
            target_raw_c = bus.i_addr_jumpr;
        end else begin
            target_raw_c = bus.i_addr_jump;
        end
        target_c = target_raw_c & ~XLEN'(3);
        pc_inc_c = pc_q + XLEN'(4);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        skid_d  = skid_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc4_d   = pc4_q;
        flush_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect_c && bus.i_imem_ack) begin
                    flush_c = 1'b1;
                    pc_d    = target_c;
                    valid_d = 1'b0;
                end else if (redirect_c) begin
                    // Outstanding request must complete before the new address.
                    flush_c = 1'b1;
                    tgt_d   = target_c;
                    valid_d = 1'b0;
                    state_d = S_DROP;
                end else if (bus.i_imem_ack && (!bus.i_stall || !valid_q)) begin
                    instr_d = bus.i_imem_rdata;
                    pc4_d   = pc_inc_c;
                    valid_d = 1'b1;
                    pc_d    = pc_inc_c;
                end else if (bus.i_imem_ack) begin
                    skid_d  = bus.i_imem_rdata;
                    pc_d    = pc_inc_c;
                    state_d = S_HOLD;
                end else if (!bus.i_stall) begin
                    valid_d = 1'b0;
                end
            end
            S_DROP: begin
                if (bus.i_imem_ack) begin
                    pc_d    = tgt_q;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (!bus.i_stall) begin
                    if (redirect_c) begin
                        flush_c = 1'b1;
                        valid_d = 1'b0;
                        pc_d    = target_c;
                    end else begin
                        // PC already points past the skid word.
                        instr_d = skid_q;
                        valid_d = 1'b1;
                        pc4_d   = pc_q;
                    end
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d = (state_d == S_REQ) || (state_d == S_DROP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            skid_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            pc4_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            skid_q  <= skid_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            req_q   <= req_d;
        end
    end

    assign bus.o_imem_req    = req_q;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_instr       = instr_q;
    assign bus.o_instr_valid = valid_q;
    assign bus.o_addr_pc4    = pc4_q;
    assign bus.o_flush       = flush_c;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Directed bench for f_fetch_ctrl: per-cycle vector table on a zero-wait
// memory, plus hand sequences for wrap, DROP and reset-in-DROP.
module tb_f_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    f_fetch_ctrl_if bus ();

    f_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Memory model: ack on the lat-th cycle of a request, data = address.
    int       lat = 1;
    logic     ack_force = 1'b0;
    logic [3:0] cnt;

    assign bus.i_imem_ack   = ack_force | (bus.o_imem_req && (cnt == 4'(lat - 1)));
    assign bus.i_imem_rdata = bus.o_imem_addr;

    always @(posedge clk) begin
        if (rst || !bus.o_imem_req || bus.i_imem_ack) cnt <= 4'd0;
        else cnt <= cnt + 4'd1;
    end

    // Wrong-path leak monitor.
    logic mon_en = 1'b0;
    logic leak   = 1'b0;
    always @(negedge clk) begin
        if (mon_en && bus.o_instr_valid && bus.o_instr == 32'h20) leak <= 1'b1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic [31:0] instr, input logic valid,
                              input logic [31:0] pc4, input logic flush);
        check({tag, ".req"},   32'(bus.o_imem_req),    32'(req));
        check({tag, ".addr"},  bus.o_imem_addr,        addr);
        check({tag, ".instr"}, bus.o_instr,            instr);
        check({tag, ".valid"}, 32'(bus.o_instr_valid), 32'(valid));
        check({tag, ".pc4"},   bus.o_addr_pc4,         pc4);
        check({tag, ".flush"}, 32'(bus.o_flush),       32'(flush));
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic drive(input logic stall, input logic [1:0] jump, input logic ifbr);
        @(negedge clk);
        bus.i_stall        = stall;
        bus.i_con_jump     = jump;
        bus.i_con_ifbranch = ifbr;
        #1;
    endtask

    task automatic do_reset(input int latency);
        rst = 1'b1;
        lat = latency;
        drive(1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Idle until a fresh, not-yet-acked request for address a is on the bus.
    task automatic reach(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (bus.o_imem_req && bus.o_imem_addr == a && !bus.i_imem_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic        stall;
        logic [1:0]  jump;
        logic        ifbr;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc4;
        logic        flush;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        bit ok;
        bit got;

        //          stall jump  br  req addr          instr         vld pc4           fl
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0,    1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0,    1'b0, 32'h0,    1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h4,    32'h0,    1'b1, 32'h4,    1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h8,    32'h4,    1'b1, 32'h8,    1'b0};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'hC,    32'h8,    1'b1, 32'hC,    1'b1};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h40,   32'h8,    1'b0, 32'hC,    1'b0};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 1'b1, 32'h44,   32'h40,   1'b1, 32'h44,   1'b0};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h48,   32'h40,   1'b1, 32'h44,   1'b0};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h48,   32'h40,   1'b1, 32'h44,   1'b0};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h48,   32'h40,   1'b1, 32'h44,   1'b0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h48,   32'h40,   1'b1, 32'h44,   1'b0};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h48,   32'h44,   1'b1, 32'h48,   1'b0};
        vecs[12] = '{1'b1, 2'b10, 1'b0, 1'b1, 32'h4C,   32'h48,   1'b1, 32'h4C,   1'b0};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h50,   32'h48,   1'b1, 32'h4C,   1'b1};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h1000, 32'h48,   1'b0, 32'h4C,   1'b0};
        vecs[15] = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h1004, 32'h1000, 1'b1, 32'h1004, 1'b1};
        vecs[16] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h80,   32'h1000, 1'b0, 32'h1004, 1'b0};
        vecs[17] = '{1'b0, 2'b11, 1'b0, 1'b1, 32'h84,   32'h80,   1'b1, 32'h84,   1'b0};
        vecs[18] = '{1'b0, 2'b00, 1'b0, 1'b1, 32'h88,   32'h84,   1'b1, 32'h88,   1'b0};

        bus.i_stall        = 1'b0;
        bus.i_con_jump     = 2'b00;
        bus.i_con_ifbranch = 1'b0;
        bus.i_addr_branch  = 32'h40;
        bus.i_addr_jump    = 32'h80;
        bus.i_addr_jumpr   = 32'h1003;

        // Reset values with zero-wait memory.
        rst = 1'b1;
        lat = 1;
        drive(1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        check_outs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Vector table: streaming, branch-over-jump, stall/skid, stall-beats-redirect, jr, j.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst                = 1'b0;
            bus.i_stall        = vecs[i].stall;
            bus.i_con_jump     = vecs[i].jump;
            bus.i_con_ifbranch = vecs[i].ifbr;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].instr,
                       vecs[i].valid, vecs[i].pc4, vecs[i].flush);
        end

        // PC wrap: branch to a misaligned 0xFFFF_FFFD lands on 0xFFFF_FFFC, then 0.
        bus.i_addr_branch = 32'hFFFF_FFFD;
        drive(1'b0, 2'b00, 1'b1);
        check_outs("wrap0", 1'b1, 32'h8C, 32'h88, 1'b1, 32'h8C, 1'b1);
        drive(1'b0, 2'b00, 1'b0);
        check_outs("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h88, 1'b0, 32'h8C, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        check_outs("wrap2", 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0);

        // jr while fetch 0x20 is outstanding on a 3-cycle memory.
        do_reset(3);
        reach(32'h20, ok);
        check("drop.reach", 32'(ok), 32'd1);
        bus.i_con_jump = 2'b10;
        #1;
        check("drop.flush", 32'(bus.o_flush), 32'd1);
        check("drop.prev_valid", 32'(bus.o_instr_valid), 32'd1);
        check("drop.prev_instr", bus.o_instr, 32'h1C);
        mon_en = 1'b1;
        drive(1'b0, 2'b00, 1'b0);
        check_outs("drop1", 1'b1, 32'h20, 32'h1C, 1'b0, 32'h20, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        check_outs("drop2", 1'b1, 32'h20, 32'h1C, 1'b0, 32'h20, 1'b0);
        check("drop2.ack", 32'(bus.i_imem_ack), 32'd1);
        drive(1'b0, 2'b00, 1'b0);
        check_outs("drop3", 1'b1, 32'h1000, 32'h1C, 1'b0, 32'h20, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'b00, 1'b0);
            if (bus.o_instr_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("drop.target_seen", 32'(got), 32'd1);
        check("drop.target_instr", bus.o_instr, 32'h1000);
        check("drop.target_pc4", bus.o_addr_pc4, 32'h1004);
        check("drop.no_leak", 32'(leak), 32'd0);
        mon_en = 1'b0;

        // Reset asserted while in DROP; a late ack in IDLE must be ignored.
        do_reset(3);
        reach(32'h20, ok);
        check("rstdrop.reach", 32'(ok), 32'd1);
        bus.i_con_jump = 2'b10;
        #1;
        check("rstdrop.flush", 32'(bus.o_flush), 32'd1);
        drive(1'b0, 2'b00, 1'b0);
        check_outs("rstdrop.in_drop", 1'b1, 32'h20, 32'h1C, 1'b0, 32'h20, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        ack_force = 1'b1;
        #1;
        check_outs("rstdrop.after", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        ack_force = 1'b0;
        lat       = 4;
        #1;
        check_outs("rstdrop.idle_ack", 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
